// File: rtl/ethernet_frame_parser.sv
// Ethernet receive-path frame parser.
// Captures the MAC header, filters on destination address, streams payload
// with the trailing 4-byte FCS held back and discarded, and classifies each
// frame as good, bad or dropped one cycle after frame end.
module ethernet_frame_parser #(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC   = 1'b0,
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        byte_ready_i,
    input  logic [7:0]  byte_i,
    input  logic        preamble_detected_i,
    input  logic        frame_end_i,
    output logic [47:0] dest_mac_o,
    output logic [47:0] src_mac_o,
    output logic [15:0] ethertype_o,
    output logic        header_valid_o,
    output logic        payload_valid_o,
    output logic [7:0]  payload_byte_o,
    output logic        frame_good_o,
    output logic        frame_bad_o,
    output logic        frame_dropped_o
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] HDR        = 3'd1;
    localparam logic [2:0] PAYLOAD    = 3'd2;
    localparam logic [2:0] DROP       = 3'd3;
    localparam logic [2:0] WAIT_CLEAR = 3'd4;

    localparam logic [10:0] MIN_C = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_C = 11'(MAX_FRAME);

    logic [2:0]       state_q, state_d;
    logic [10:0]      cnt_q, cnt_d;
    logic [2:0]       fill_q, fill_d;
    logic [3:0][7:0]  sr_q, sr_d;      // [3] is the oldest byte
    logic [47:0]      dest_q, dest_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic             hv_q, hv_d;
    logic             pv_q, pv_d;
    logic [7:0]       pb_q, pb_d;
    logic             good_q, good_d;
    logic             bad_q, bad_d;
    logic             drop_q, drop_d;

    logic             in_frame_s;
    logic             accept_s;
    logic [10:0]      cnt_inc_s;
    logic [47:0]      dest_next_s;
    logic             dest_ok_s;

    assign in_frame_s  = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == DROP);
    assign accept_s    = byte_ready_i && preamble_detected_i && in_frame_s;
    assign cnt_inc_s   = (cnt_q == 11'h7FF) ? cnt_q : (cnt_q + 11'd1);
    assign dest_next_s = {dest_q[39:0], byte_i};
    assign dest_ok_s   = PROMISC || (dest_next_s == MAC_ADDR) || (dest_next_s == 48'hFFFF_FFFF_FFFF);

    // Next-state logic: byte handling first, then frame close in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        sr_d    = sr_q;
        dest_d  = dest_q;
        src_d   = src_q;
        type_d  = type_q;
        hv_d    = 1'b0;
        pv_d    = 1'b0;
        pb_d    = pb_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (preamble_detected_i) begin
                    state_d = HDR;
                    cnt_d   = 11'd0;
                    fill_d  = 3'd0;
                    sr_d    = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (accept_s) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_q < 11'd6) begin
                        dest_d = dest_next_s;
                    end else if (cnt_q < 11'd12) begin
                        src_d = {src_q[39:0], byte_i};
                    end else begin
                        type_d = {type_q[7:0], byte_i};
                    end
                    if (cnt_q == 11'd5) begin
                        state_d = dest_ok_s ? HDR : DROP;
                    end else if (cnt_q == 11'd13) begin
                        hv_d    = 1'b1;
                        state_d = PAYLOAD;
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            PAYLOAD: begin
                if (accept_s) begin
                    cnt_d = cnt_inc_s;
                    sr_d  = {sr_q[2:0], byte_i};
                    if (fill_q == 3'd4) begin
                        pv_d = 1'b1;
                        pb_d = sr_q[3];
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            DROP: begin
                if (accept_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    state_d = DROP;
                end
            end
            WAIT_CLEAR: begin
                if (!preamble_detected_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame close sees the state and count as updated by this cycle's byte.
        if (frame_end_i && in_frame_s) begin
            if (state_d == DROP) begin
                drop_d = 1'b1;
            end else if ((state_d == HDR) || (cnt_d < MIN_C) || (cnt_d > MAX_C)) begin
                bad_d = 1'b1;
            end else begin
                good_d = 1'b1;
            end
            fill_d  = 3'd0;
            sr_d    = 32'd0;
            state_d = WAIT_CLEAR;
        end else begin
            fill_d = fill_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 11'd0;
            fill_q  <= 3'd0;
            sr_q    <= 32'd0;
            dest_q  <= 48'd0;
            src_q   <= 48'd0;
            type_q  <= 16'd0;
            hv_q    <= 1'b0;
            pv_q    <= 1'b0;
            pb_q    <= 8'd0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            sr_q    <= sr_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            type_q  <= type_d;
            hv_q    <= hv_d;
            pv_q    <= pv_d;
            pb_q    <= pb_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            drop_q  <= drop_d;
        end
    end

    assign dest_mac_o      = dest_q;
    assign src_mac_o       = src_q;
    assign ethertype_o     = type_q;
    assign header_valid_o  = hv_q;
    assign payload_valid_o = pv_q;
    assign payload_byte_o  = pb_q;
    assign frame_good_o    = good_q;
    assign frame_bad_o     = bad_q;
    assign frame_dropped_o = drop_q;

endmodule

// File: doc/ethernet_frame_parser.md
# ethernet_frame_parser

Receive-path stage that sits directly downstream of the Ethernet preamble/SFD detector and shares its byte stream. Once the detector reports the start-frame delimiter, this block parses the MAC header, filters on destination address, and streams payload bytes with the 4-byte FCS stripped. At frame end it classifies the frame as good, bad or dropped.

## Interface

Parameters:
- `MAC_ADDR`, default 48'h02_00_00_00_00_01: station address accepted as unicast destination; header byte 0 = MAC_ADDR[47:40].
- `PROMISC`, default 0: 1 = accept every destination.
- `MIN_FRAME`, default 64: minimum legal frame length in bytes, header+payload+FCS.
- `MAX_FRAME`, default 1518: maximum legal frame length in bytes, same basis.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `byte_ready`  in  1  qualifier for `byte`, one-cycle strobe per received byte.
- `byte`  in  8  received byte.
- `preamble_detected`  in  1  level from the SFD detector; high from the second cycle after the SFD byte until the detector is reset.
- `frame_end`  in  1  one-cycle pulse when the PHY drops data-valid.
- `dest_mac`  out  48  captured destination address.
- `src_mac`  out  48  captured source address.
- `ethertype`  out  16  captured type/length field, first byte in [15:8].
- `header_valid`  out  1  one-cycle pulse when header is complete and the destination is accepted.
- `payload_valid`  out  1  one-cycle strobe qualifying `payload_byte`.
- `payload_byte`  out  8  payload byte, FCS excluded.
- `frame_good`  out  1  one-cycle pulse; accepted frame with legal length.
- `frame_bad`  out  1  one-cycle pulse; accepted frame that is runt, oversize or truncated in header.
- `frame_dropped`  out  1  one-cycle pulse; destination filtered out.

## Operation

- A byte is accepted when `byte_ready && preamble_detected` in states HDR, PAYLOAD or DROP.
- States:
  - IDLE: waits for `preamble_detected`, then goes to HDR.
  - HDR: bytes 0–5 → `dest_mac`, 6–11 → `src_mac`, 12–13 → `ethertype`, all MSB-first.
  - After byte 5, the filter is evaluated. Destination accepted if it equals `MAC_ADDR`, equals 48'hFFFF_FFFF_FFFF, or `PROMISC`=1. Otherwise go to DROP.
  - After byte 13: pulse `header_valid`, go to PAYLOAD.
  - PAYLOAD: every accepted byte is pushed into a 4-entry shift register. Once the register holds 4 bytes, each push emits the oldest entry as `payload_byte` with `payload_valid`.
  - DROP: bytes are counted only; no payload output.
  - WAIT_CLEAR: entered after `frame_end` is processed; returns to IDLE when `preamble_detected` is low.
- `frame_end` in HDR, PAYLOAD or DROP closes the frame. The 4 bytes held in the shift register are the FCS and are discarded; the shift register is cleared.
- Byte counter: 11 bits, counts every accepted byte of the frame, saturates at 2047, cleared on entry to HDR.
- Classification at frame end, exactly one pulse:
  - `frame_dropped` if the frame ended in DROP.
  - `frame_bad` if it ended in HDR, or count < `MIN_FRAME`, or count > `MAX_FRAME`.
  - `frame_good` otherwise.
- `frame_end` in IDLE or WAIT_CLEAR is ignored and produces no pulse.
- Header registers hold their values until overwritten by the next frame.
- Simultaneous `byte_ready` and `frame_end`: the byte is accepted and counted first, then the frame is closed in the same cycle.
- `reset` mid-frame: state → IDLE, counter and shift register cleared, no classification pulse.

## Timing

- Reset values:
  - All outputs 0.
  - `dest_mac`, `src_mac`, `ethertype` = 0.
  - State IDLE.
- All outputs are registered.
- `header_valid`: high the cycle after byte 13 is accepted.
- `payload_valid`: high the cycle after the accept that pushes payload byte n+4. Payload byte n therefore leaves 4 accepted bytes after it arrives, plus 1 cycle.
- Classification pulse: the cycle after the `frame_end` cycle.
- A `frame_end` with a simultaneous last byte never produces `payload_valid` for that byte; it is FCS.
- Throughput: one byte per cycle sustained; `byte_ready` may be asserted back-to-back.

## Test plan

- Unicast to `MAC_ADDR`, 46-byte payload 0x00..0x2D, 4 FCS bytes, total 64 → `header_valid` once, 46 `payload_valid` strobes with values 0x00..0x2D in order, FCS never emitted, `frame_good` one cycle after `frame_end`.
- Broadcast destination FF×6, 100-byte payload → accepted; `ethertype` matches bytes 12–13; `frame_good`.
- Destination 02:00:00:00:00:02 with `PROMISC`=0 → no `header_valid`, no payload, `frame_dropped`. Same frame with `PROMISC`=1 → `frame_good`.
- Runt frame, 40 bytes total → 22 payload strobes, then `frame_bad`. 1519-byte frame → `frame_bad`. `frame_end` after byte 9 → no `header_valid`, `frame_bad`.
- Last FCS byte presented in the same cycle as `frame_end` → count includes it, no extra `payload_valid`. Back-to-back `byte_ready` for a full 64-byte frame → no byte lost.
- `reset` asserted mid-payload → all outputs 0 next cycle, no classification pulse. A following frame, after `preamble_detected` toggles low then high, parses correctly.
